// File: rtl/alu_pkg.sv
// Shared constants and helpers for the ALU operation sequencer.
// Opcode map, FSM encoding and datapath widths.
package alu_pkg;

    localparam int OPND_W = 8;
    localparam int RES_W  = 16;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_NOTB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Logical ops yield an 8-bit result; the upper byte is don't-care.
    function automatic logic is_logic_op(input logic [2:0] op);
        return !(op == OP_ADD || op == OP_SUB || op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// 4-bit loadable down-counter timing the ALU settle latency.
// Load has priority; counting stops at zero.
module alu_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the 8-way ALU result selector:
// accept op, drive operands, wait settle latency, return result.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int FAST_LAT   = 1,
    parameter int MUL_LAT    = 4,
    parameter bit MASK_LOGIC = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    output logic [2:0]        sel,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [2:0]        rsp_op,
    output logic              busy,
    output logic [15:0]       op_count
);

    if (FAST_LAT < 1 || FAST_LAT > 15) begin : g_fast_chk
        $error("FAST_LAT must be in 1..15");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_mul_chk
        $error("MUL_LAT must be in 1..15");
    end

    localparam logic [3:0] FAST_LD = 4'(FAST_LAT - 1);
    localparam logic [3:0] MUL_LD  = 4'(MUL_LAT - 1);

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        capture;
    logic        rsp_done;
    logic        wait_en;
    logic        cnt_zero;
    logic [3:0]  ld_val;
    logic [15:0] count_q;
    logic        mask_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        wait_en   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_en = 1'b1;
                capture = cnt_zero;
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_done  = rsp_ready;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ld_val  = (cmd_op == OP_MUL) ? MUL_LD : FAST_LD;
    assign mask_hi = MASK_LOGIC && is_logic_op(sel);

    alu_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (ld_val),
        .en       (wait_en),
        .zero     (cnt_zero)
    );

    // Operands stay on the bus until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= 3'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_op   <= 3'd0;
            count_q  <= 16'd0;
        end else begin
            if (accept) begin
                sel   <= cmd_op;
                alu_a <= cmd_a;
                alu_b <= cmd_b;
            end
            if (capture) begin
                rsp_data <= mask_hi ? {8'h00, alu_y[7:0]} : alu_y;
                rsp_op   <= sel;
            end
            if (rsp_done) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign op_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios
// plus randomized ops against a behavioural response model.
module tb_alu_op_sequencer;

    localparam int FAST = 1;
    localparam int MULL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic        rsp_ready = 1'b0;
    logic [15:0] noise = 16'd0;

    logic        cmd_ready, rsp_valid, busy;
    logic [2:0]  sel, rsp_op;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_y, rsp_data, op_count;

    logic        cmd_ready2, rsp_valid2, busy2;
    logic [2:0]  sel2, rsp_op2;
    logic [7:0]  alu_a2, alu_b2;
    logic [15:0] alu_y2, rsp_data2, op_count2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Function units + result mux as seen by the sequencer.
    function automatic logic [15:0] alu_fn(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] d9;
        d9 = {1'b0, a} - {1'b0, b};
        case (op)
            3'd0: return ~{8'h00, a};
            3'd1: return {8'h00, a | b};
            3'd2: return {8'h00, a & b};
            3'd3: return {8'h00, a ^ b};
            3'd4: return {8'h00, a} + {8'h00, b};
            3'd5: return {7'h00, d9};
            3'd6: return {8'h00, a} * {8'h00, b};
            default: return ~{8'h00, b};
        endcase
    endfunction

    function automatic logic [15:0] exp_data(input logic [2:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b,
                                             input bit mask);
        logic [15:0] y;
        y = alu_fn(op, a, b);
        if (mask && (op <= 3'd3 || op == 3'd7)) return {8'h00, y[7:0]};
        return y;
    endfunction

    assign alu_y  = alu_fn(sel, alu_a, alu_b) ^ noise;
    assign alu_y2 = alu_fn(sel2, alu_a2, alu_b2) ^ noise;

    alu_op_sequencer #(.FAST_LAT(FAST), .MUL_LAT(MULL), .MASK_LOGIC(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .sel(sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op),
        .busy(busy), .op_count(op_count)
    );

    alu_op_sequencer #(.FAST_LAT(FAST), .MUL_LAT(MULL), .MASK_LOGIC(1'b0)) dut_nm (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .sel(sel2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_y(alu_y2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .rsp_op(rsp_op2),
        .busy(busy2), .op_count(op_count2)
    );

    // Drives one transaction; returns observations only.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold,
                         output int lat, output logic [15:0] d,
                         output logic [15:0] d2, output logic [2:0] o,
                         output bit stable, output bit rdy_after,
                         output bit tmo);
        int n;
        int t0;
        tmo = 1'b0;
        stable = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) tmo = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom);
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) tmo = 1'b1;
        lat = cyc - t0;
        d = rsp_data;
        d2 = rsp_data2;
        o = rsp_op;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            noise = 16'($urandom);
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d || rsp_op !== o || cmd_ready)
                stable = 1'b0;
        end
        cmd_valid = 1'b0;
        noise = 16'd0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        rdy_after = cmd_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, want 1 0 0",
                     cmd_ready, rsp_valid, busy);
        end
        checks++;
        if (sel !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_bus: sel=%h a=%h b=%h, want 0", sel, alu_a, alu_b);
        end
        checks++;
        if (rsp_data !== 16'd0 || rsp_op !== 3'd0 || op_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_rsp: data=%h op=%h cnt=%h, want 0",
                     rsp_data, rsp_op, op_count);
        end
        exp_cnt = 16'd0;
    endtask

    task automatic test_add;
        int lat;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        do_op(3'b100, 8'h05, 8'h03, 0, lat, d, d2, o, st, ra, tmo);
        exp_cnt++;
        checks++;
        if (tmo || lat != FAST) begin
            failures++;
            $display("FAIL add_latency: got %0d (timeout=%0d), want %0d", lat, tmo, FAST);
        end
        checks++;
        if (d !== 16'h0008 || o !== 3'b100) begin
            failures++;
            $display("FAIL add_data: got %h op %b, want 0008 op 100", d, o);
        end
        checks++;
        if (op_count !== exp_cnt || ra !== 1'b1) begin
            failures++;
            $display("FAIL add_count: cnt=%h ready=%b, want %h 1", op_count, ra, exp_cnt);
        end
    endtask

    task automatic test_mul;
        int lat;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        do_op(3'b110, 8'h0C, 8'h0A, 1, lat, d, d2, o, st, ra, tmo);
        exp_cnt++;
        checks++;
        if (tmo || lat != MULL) begin
            failures++;
            $display("FAIL mul_latency: got %0d (timeout=%0d), want %0d", lat, tmo, MULL);
        end
        checks++;
        if (d !== 16'h0078 || d2 !== 16'h0078 || op_count !== exp_cnt) begin
            failures++;
            $display("FAIL mul_data: got %h/%h cnt %h, want 0078 cnt %h",
                     d, d2, op_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        do_op(3'b101, 8'h03, 8'h05, 3, lat, d, d2, o, st, ra, tmo);
        exp_cnt++;
        checks++;
        if (tmo || d !== 16'h01FE || o !== 3'b101) begin
            failures++;
            $display("FAIL bp_data: got %h op %b, want 01fe op 101", d, o);
        end
        checks++;
        if (!st) begin
            failures++;
            $display("FAIL bp_stable: response changed or ready rose while stalled, want stable");
        end
        checks++;
        if (ra !== 1'b1 || sel !== 3'b101 || alu_a !== 8'h03 || op_count !== exp_cnt) begin
            failures++;
            $display("FAIL bp_after: ready=%b sel=%b a=%h cnt=%h, want 1 101 03 %h",
                     ra, sel, alu_a, op_count, exp_cnt);
        end
    endtask

    task automatic test_mask;
        int lat;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        do_op(3'b000, 8'h05, 8'h77, 0, lat, d, d2, o, st, ra, tmo);
        exp_cnt++;
        checks++;
        if (tmo || d !== 16'h00FA) begin
            failures++;
            $display("FAIL mask_on: got %h, want 00fa", d);
        end
        checks++;
        if (d2 !== 16'hFFFA) begin
            failures++;
            $display("FAIL mask_off: got %h, want fffa", d2);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        cmd_op = 3'b110;
        cmd_a = 8'h11;
        cmd_b = 8'h22;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || op_count !== 16'd0 || sel !== 3'd0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state: busy=%b cnt=%h sel=%b valid=%b, want 0 0 0 0",
                     busy, op_count, sel, rsp_valid);
        end
        exp_cnt = 16'd0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rstmid_norsp: rsp_valid seen %0d cycles, want 0", seen);
        end
        do_op(3'b010, 8'hF0, 8'h3C, 0, lat, d, d2, o, st, ra, tmo);
        exp_cnt++;
        checks++;
        if (tmo || d !== 16'h0030 || op_count !== exp_cnt) begin
            failures++;
            $display("FAIL rstmid_next: got %h cnt %h, want 0030 cnt %h", d, op_count, exp_cnt);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        logic [2:0] op;
        logic [7:0] a, b;
        int hold;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            hold = int'($urandom_range(0, 3));
            do_op(op, a, b, hold, lat, d, d2, o, st, ra, tmo);
            exp_cnt++;
            checks++;
            if (tmo || lat != ((op == 3'b110) ? MULL : FAST)) begin
                failures++;
                $display("FAIL rnd_latency[%0d]: op %b got %0d, want %0d",
                         k, op, lat, (op == 3'b110) ? MULL : FAST);
            end
            checks++;
            if (d !== exp_data(op, a, b, 1'b1) || o !== op) begin
                failures++;
                $display("FAIL rnd_data[%0d]: op %b a %h b %h got %h/%b, want %h/%b",
                         k, op, a, b, d, o, exp_data(op, a, b, 1'b1), op);
            end
            checks++;
            if (d2 !== exp_data(op, a, b, 1'b0)) begin
                failures++;
                $display("FAIL rnd_nomask[%0d]: got %h, want %h",
                         k, d2, exp_data(op, a, b, 1'b0));
            end
            checks++;
            if (!st || ra !== 1'b1 || op_count !== exp_cnt) begin
                failures++;
                $display("FAIL rnd_hs[%0d]: stable=%0d ready=%b cnt=%h, want 1 1 %h",
                         k, st, ra, op_count, exp_cnt);
            end
        end
    endtask

    task automatic test_wrap;
        int lat;
        logic [15:0] d, d2;
        logic [2:0] o;
        bit st, ra, tmo;
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        do_op(3'b011, 8'h5A, 8'hFF, 0, lat, d, d2, o, st, ra, tmo);
        checks++;
        if (tmo || d !== 16'h00A5) begin
            failures++;
            $display("FAIL wrap_data: got %h, want 00a5", d);
        end
        checks++;
        if (op_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_count: got %h, want 0000", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_backpressure();
        test_mask();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
